// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: opcode and ALU-op encodings and operand selects.
package id_ex_stage_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU opcodes consumed by EX
  localparam logic [3:0] ALUOP_AND  = 4'b0000;
  localparam logic [3:0] ALUOP_OR   = 4'b0001;
  localparam logic [3:0] ALUOP_ADD  = 4'b0010;
  localparam logic [3:0] ALUOP_XOR  = 4'b0011;
  localparam logic [3:0] ALUOP_SLL  = 4'b0100;
  localparam logic [3:0] ALUOP_SRL  = 4'b0101;
  localparam logic [3:0] ALUOP_SUB  = 4'b0110;
  localparam logic [3:0] ALUOP_SLTU = 4'b0111;
  localparam logic [3:0] ALUOP_SLT  = 4'b1000;
  localparam logic [3:0] ALUOP_SRA  = 4'b1001;

  // funct7 values that select the base / alternate operation
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    InaRs1,
    InaZero,
    InaPc
  } ina_sel_e;

  typedef enum logic [1:0] {
    InbRs2,
    InbImm,
    InbFour
  } inb_sel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  // Base funct3 -> ALU op mapping shared by register and immediate ALU forms
  function automatic logic [3:0] funct3_aluop(input logic [2:0] funct3);
    logic [3:0] op;
    unique case (funct3)
      3'b000:  op = ALUOP_ADD;
      3'b001:  op = ALUOP_SLL;
      3'b010:  op = ALUOP_SLT;
      3'b011:  op = ALUOP_SLTU;
      3'b100:  op = ALUOP_XOR;
      3'b101:  op = ALUOP_SRL;
      3'b110:  op = ALUOP_OR;
      default: op = ALUOP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side inputs and hazard controls in, registered EX-side signals out.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = id_ex_stage_pkg::XLEN
);
  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [3:0]      ex_alu_op;
  logic [XLEN-1:0] ex_ina;
  logic [XLEN-1:0] ex_inb;
  logic [XLEN-1:0] ex_store_data;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_illegal;

  // Driver side: decode stage plus hazard unit
  modport master (
    output stall, flush, id_valid, id_pc, id_opcode, id_funct3, id_funct7,
    output id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
    input  ex_valid, ex_pc, ex_alu_op, ex_ina, ex_inb, ex_store_data,
    input  ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_reg_write, ex_mem_read,
    input  ex_mem_write, ex_branch, ex_jump, ex_illegal
  );

  // Pipeline register side
  modport slave (
    input  stall, flush, id_valid, id_pc, id_opcode, id_funct3, id_funct7,
    input  id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
    output ex_valid, ex_pc, ex_alu_op, ex_ina, ex_inb, ex_store_data,
    output ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_branch, ex_jump, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALU-op decoder: opcode/funct3/funct7 -> 4-bit ALU op and illegal flag.
module id_ex_stage_alu_control
  import id_ex_stage_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       illegal
);

  // Decode the ALU operation; illegal encodings fall back to ADD
  always_comb begin
    alu_op  = ALUOP_ADD;
    illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        alu_op = funct3_aluop(funct3);
        if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_op = ALUOP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_op = ALUOP_SRA;
        end else if (funct7 != F7_BASE) begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // funct7 is immediate data except on shifts, where it carries the shift type
        alu_op = funct3_aluop(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            alu_op = ALUOP_SRA;
          end else if (funct7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end
      end
      OPC_BRANCH: begin
        unique case (funct3)
          3'b000, 3'b001: alu_op = ALUOP_SUB;
          3'b100, 3'b101: alu_op = ALUOP_SLT;
          3'b110, 3'b111: alu_op = ALUOP_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        alu_op = ALUOP_ADD;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op = ALUOP_ADD;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes control, selects ALU operands and registers them for EX.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = id_ex_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  logic [3:0]      alu_op;
  logic            illegal;
  ctrl_t           ctrl;
  ina_sel_e        ina_sel;
  inb_sel_e        inb_sel;

  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [3:0]      alu_op_d, alu_op_q;
  logic [XLEN-1:0] ina_d, ina_q;
  logic [XLEN-1:0] inb_d, inb_q;
  logic [XLEN-1:0] store_data_d, store_data_q;
  logic [4:0]      rs1_d, rs1_q;
  logic [4:0]      rs2_d, rs2_q;
  logic [4:0]      rd_d, rd_q;
  logic [2:0]      funct3_d, funct3_q;
  ctrl_t           ctrl_d, ctrl_q;

  id_ex_stage_alu_control u_alu_control (
    .opcode  (bus.id_opcode),
    .funct3  (bus.id_funct3),
    .funct7  (bus.id_funct7),
    .alu_op  (alu_op),
    .illegal (illegal)
  );

  // Control bits and operand selects per opcode class
  always_comb begin
    ctrl    = '0;
    ina_sel = InaRs1;
    inb_sel = InbRs2;
    case (bus.id_opcode)
      OPC_OP: ctrl.reg_write = 1'b1;
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        inb_sel        = InbImm;
      end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        inb_sel        = InbImm;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        inb_sel        = InbImm;
      end
      OPC_BRANCH: ctrl.branch = 1'b1;
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ina_sel        = InaZero;
        inb_sel        = InbImm;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ina_sel        = InaPc;
        inb_sel        = InbImm;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link value pc+4; the target is resolved elsewhere
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ina_sel        = InaPc;
        inb_sel        = InbFour;
      end
      default: ;
    endcase
    if (illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
    if (bus.id_rd == 5'd0) begin
      ctrl.reg_write = 1'b0;
    end
  end

  // Next register contents; an invalid ID slot becomes a bubble
  always_comb begin
    valid_d      = 1'b1;
    pc_d         = bus.id_pc;
    alu_op_d     = alu_op;
    store_data_d = bus.id_rs2_data;
    rs1_d        = bus.id_rs1;
    rs2_d        = bus.id_rs2;
    rd_d         = bus.id_rd;
    funct3_d     = bus.id_funct3;
    ctrl_d       = ctrl;
    unique case (ina_sel)
      InaZero: ina_d = '0;
      InaPc:   ina_d = bus.id_pc;
      default: ina_d = bus.id_rs1_data;
    endcase
    unique case (inb_sel)
      InbImm:  inb_d = bus.id_imm;
      InbFour: inb_d = XLEN'(4);
      default: inb_d = bus.id_rs2_data;
    endcase
    if (!bus.id_valid) begin
      valid_d      = 1'b0;
      pc_d         = RESET_PC;
      alu_op_d     = '0;
      ina_d        = '0;
      inb_d        = '0;
      store_data_d = '0;
      rs1_d        = '0;
      rs2_d        = '0;
      rd_d         = '0;
      funct3_d     = '0;
      ctrl_d       = '0;
    end
  end

  // Stage register: reset and flush insert a bubble, stall holds
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      valid_q      <= 1'b0;
      pc_q         <= RESET_PC;
      alu_op_q     <= '0;
      ina_q        <= '0;
      inb_q        <= '0;
      store_data_q <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      ctrl_q       <= '0;
    end else if (!bus.stall) begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      alu_op_q     <= alu_op_d;
      ina_q        <= ina_d;
      inb_q        <= inb_d;
      store_data_q <= store_data_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_alu_op     = alu_op_q;
  assign bus.ex_ina        = ina_q;
  assign bus.ex_inb        = inb_q;
  assign bus.ex_store_data = store_data_q;
  assign bus.ex_rs1        = rs1_q;
  assign bus.ex_rs2        = rs2_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_funct3     = funct3_q;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_branch     = ctrl_q.branch;
  assign bus.ex_jump       = ctrl_q.jump;
  assign bus.ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for the ID/EX stage with hand-written stall/flush/reset sequences.
module tb_id_ex_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] ina, inb, sd;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        rw, mr, mw, br, jp, ill;
    logic        chk_ops;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, " ex_valid"},      32'(bus.ex_valid),     32'(e.valid));
    check({tag, " ex_pc"},         bus.ex_pc,             e.pc);
    check({tag, " ex_alu_op"},     32'(bus.ex_alu_op),    32'(e.alu_op));
    check({tag, " ex_store_data"}, bus.ex_store_data,     e.sd);
    check({tag, " ex_rs1"},        32'(bus.ex_rs1),       32'(e.rs1));
    check({tag, " ex_rs2"},        32'(bus.ex_rs2),       32'(e.rs2));
    check({tag, " ex_rd"},         32'(bus.ex_rd),        32'(e.rd));
    check({tag, " ex_funct3"},     32'(bus.ex_funct3),    32'(e.f3));
    check({tag, " ex_reg_write"},  32'(bus.ex_reg_write), 32'(e.rw));
    check({tag, " ex_mem_read"},   32'(bus.ex_mem_read),  32'(e.mr));
    check({tag, " ex_mem_write"},  32'(bus.ex_mem_write), 32'(e.mw));
    check({tag, " ex_branch"},     32'(bus.ex_branch),    32'(e.br));
    check({tag, " ex_jump"},       32'(bus.ex_jump),      32'(e.jp));
    check({tag, " ex_illegal"},    32'(bus.ex_illegal),   32'(e.ill));
    if (e.chk_ops) begin
      check({tag, " ex_ina"}, bus.ex_ina, e.ina);
      check({tag, " ex_inb"}, bus.ex_inb, e.inb);
    end
  endtask

  function automatic in_t mk_in(input logic [31:0] pc, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] imm);
    in_t r;
    r.valid = 1'b1; r.pc = pc; r.op = op; r.f3 = f3; r.f7 = f7;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.d1 = d1; r.d2 = d2; r.imm = imm;
    return r;
  endfunction

  // Index, funct3, pc and store-data fields are plain pass-through of the inputs
  function automatic exp_t mk_exp(input in_t i, input logic [3:0] alu, input logic [31:0] ina,
                                  input logic [31:0] inb, input logic rw, input logic mr,
                                  input logic mw, input logic br, input logic jp,
                                  input logic ill);
    exp_t r;
    r.valid = 1'b1; r.pc = i.pc; r.alu_op = alu; r.ina = ina; r.inb = inb; r.sd = i.d2;
    r.rs1 = i.rs1; r.rs2 = i.rs2; r.rd = i.rd; r.f3 = i.f3;
    r.rw = rw; r.mr = mr; r.mw = mw; r.br = br; r.jp = jp; r.ill = ill;
    r.chk_ops = !ill;
    return r;
  endfunction

  function automatic exp_t bubble_exp();
    exp_t r;
    r.valid = 1'b0; r.pc = RST_PC; r.alu_op = 4'd0; r.ina = '0; r.inb = '0; r.sd = '0;
    r.rs1 = '0; r.rs2 = '0; r.rd = '0; r.f3 = '0;
    r.rw = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.br = 1'b0; r.jp = 1'b0; r.ill = 1'b0;
    r.chk_ops = 1'b1;
    return r;
  endfunction

  task automatic drive(input in_t i);
    bus.id_valid    = i.valid;
    bus.id_pc       = i.pc;
    bus.id_opcode   = i.op;
    bus.id_funct3   = i.f3;
    bus.id_funct7   = i.f7;
    bus.id_rs1      = i.rs1;
    bus.id_rs2      = i.rs2;
    bus.id_rd       = i.rd;
    bus.id_rs1_data = i.d1;
    bus.id_rs2_data = i.d2;
    bus.id_imm      = i.imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input in_t i, input exp_t e);
    vec_t v;
    v.name = n; v.in = i; v.exp = e;
    vecs.push_back(v);
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;

  initial begin
    in_t  i;
    in_t  i_add, i_lw, i_jal;
    exp_t e_add, e_lw, e_jal;

    // ---------------- vector table ----------------
    i = mk_in(32'h10, R, 3'b000, 7'h00, 5'd1, 5'd2, 5'd5, 32'h10, 32'h3, 32'h0);
    add_vec("add", i, mk_exp(i, 4'b0010, 32'h10, 32'h3, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'h14, R, 3'b000, 7'h20, 5'd3, 5'd4, 5'd6, 32'h50, 32'h8, 32'h0);
    add_vec("sub", i, mk_exp(i, 4'b0110, 32'h50, 32'h8, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'h18, I, 3'b101, 7'h20, 5'd7, 5'd4, 5'd8, 32'h8000_0000, 32'h1234, 32'h4);
    add_vec("srai", i, mk_exp(i, 4'b1001, 32'h8000_0000, 32'h4, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'h1c, R, 3'b000, 7'h01, 5'd1, 5'd2, 5'd9, 32'h5, 32'h6, 32'h0);
    add_vec("r_f7_bad", i, mk_exp(i, 4'b0010, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1));
    i = mk_in(32'h20, LD, 3'b010, 7'h7f, 5'd10, 5'd24, 5'd11, 32'h100, 32'h0, 32'hFFFF_FFF8);
    add_vec("lw", i, mk_exp(i, 4'b0010, 32'h100, 32'hFFFF_FFF8, 1, 1, 0, 0, 0, 0));
    i = mk_in(32'h24, ST, 3'b010, 7'h00, 5'd12, 5'd13, 5'd4, 32'h200, 32'hDEAD_BEEF, 32'h4);
    add_vec("sw", i, mk_exp(i, 4'b0010, 32'h200, 32'h4, 0, 0, 1, 0, 0, 0));
    i = mk_in(32'h28, BR, 3'b110, 7'h00, 5'd1, 5'd2, 5'd8, 32'h3, 32'h9, 32'h10);
    add_vec("bltu", i, mk_exp(i, 4'b0111, 32'h3, 32'h9, 0, 0, 0, 1, 0, 0));
    i = mk_in(32'h2c, BR, 3'b000, 7'h00, 5'd3, 5'd4, 5'd0, 32'h7, 32'h7, 32'h20);
    add_vec("beq", i, mk_exp(i, 4'b0110, 32'h7, 32'h7, 0, 0, 0, 1, 0, 0));
    i = mk_in(32'h30, BR, 3'b100, 7'h00, 5'd3, 5'd4, 5'd0, 32'h1, 32'h2, 32'h20);
    add_vec("blt", i, mk_exp(i, 4'b1000, 32'h1, 32'h2, 0, 0, 0, 1, 0, 0));
    i = mk_in(32'h34, BR, 3'b010, 7'h00, 5'd3, 5'd4, 5'd0, 32'h1, 32'h2, 32'h20);
    add_vec("br_f3_bad", i, mk_exp(i, 4'b0010, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1));
    i = mk_in(32'h40, 7'b0010111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd3, 32'h999, 32'h0, 32'h1000);
    add_vec("auipc", i, mk_exp(i, 4'b0010, 32'h40, 32'h1000, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'h44, 7'b0110111, 3'b101, 7'h09, 5'd6, 5'd5, 5'd4, 32'h777, 32'h0, 32'h1234_5000);
    add_vec("lui", i, mk_exp(i, 4'b0010, 32'h0, 32'h1234_5000, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'h80, 7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'h55, 32'h0, 32'h100);
    add_vec("jal", i, mk_exp(i, 4'b0010, 32'h80, 32'h4, 1, 0, 0, 0, 1, 0));
    i = mk_in(32'h84, 7'b1100111, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h66, 32'h0, 32'h8);
    add_vec("jalr_rd0", i, mk_exp(i, 4'b0010, 32'h84, 32'h4, 0, 0, 0, 0, 1, 0));
    i = mk_in(32'h88, I, 3'b000, 7'h7f, 5'd2, 5'd31, 5'd0, 32'h7, 32'h0, 32'hFFFF_FFFF);
    add_vec("addi_rd0", i, mk_exp(i, 4'b0010, 32'h7, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
    i = mk_in(32'h8c, I, 3'b100, 7'h20, 5'd2, 5'd3, 5'd9, 32'hF0, 32'h0, 32'h40F);
    add_vec("xori", i, mk_exp(i, 4'b0011, 32'hF0, 32'h40F, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'h90, I, 3'b001, 7'h20, 5'd2, 5'd3, 5'd9, 32'h1, 32'h0, 32'h403);
    add_vec("slli_bad", i, mk_exp(i, 4'b0010, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1));
    i = mk_in(32'h94, R, 3'b011, 7'h00, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0);
    add_vec("sltu", i, mk_exp(i, 4'b0111, 32'h1, 32'h2, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'h98, R, 3'b100, 7'h00, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'h0);
    add_vec("xor", i, mk_exp(i, 4'b0011, 32'hA, 32'hB, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'h9c, R, 3'b101, 7'h00, 5'd1, 5'd2, 5'd3, 32'hC, 32'hD, 32'h0);
    add_vec("srl", i, mk_exp(i, 4'b0101, 32'hC, 32'hD, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'ha0, R, 3'b001, 7'h00, 5'd1, 5'd2, 5'd3, 32'h1, 32'h5, 32'h0);
    add_vec("sll", i, mk_exp(i, 4'b0100, 32'h1, 32'h5, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'ha4, R, 3'b010, 7'h00, 5'd1, 5'd2, 5'd3, 32'h1, 32'h5, 32'h0);
    add_vec("slt", i, mk_exp(i, 4'b1000, 32'h1, 32'h5, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'ha8, R, 3'b110, 7'h00, 5'd1, 5'd2, 5'd3, 32'h3, 32'h4, 32'h0);
    add_vec("or", i, mk_exp(i, 4'b0001, 32'h3, 32'h4, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'hac, R, 3'b111, 7'h00, 5'd1, 5'd2, 5'd3, 32'h3, 32'h4, 32'h0);
    add_vec("and", i, mk_exp(i, 4'b0000, 32'h3, 32'h4, 1, 0, 0, 0, 0, 0));
    i = mk_in(32'hb0, 7'b1111111, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h3, 32'h4, 32'h0);
    add_vec("bad_opc", i, mk_exp(i, 4'b0010, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1));
    i = mk_in(32'hb4, R, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h3, 32'h4, 32'h0);
    i.valid = 1'b0;
    add_vec("id_invalid", i, bubble_exp());

    i_add = vecs[0].in;  e_add = vecs[0].exp;
    i_lw  = vecs[4].in;  e_lw  = vecs[4].exp;
    i_jal = vecs[12].in; e_jal = vecs[12].exp;

    // ---------------- reset for two cycles with live inputs ----------------
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(i_add);
    tick();
    tick();
    check_out("reset", bubble_exp());
    reset = 1'b0;

    // ---------------- table: one instruction per cycle ----------------
    foreach (vecs[k]) begin
      drive(vecs[k].in);
      tick();
      check_out(vecs[k].name, vecs[k].exp);
    end

    // ---------------- stall holds through changing inputs ----------------
    drive(i_add);
    tick();
    check_out("pre_stall", e_add);
    bus.stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive(vecs[k * 4].in);
      tick();
      check_out($sformatf("stall_%0d", k), e_add);
    end

    // flush wins over stall
    bus.flush = 1'b1;
    tick();
    check_out("flush_stall", bubble_exp());
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // ---------------- plain flush after a valid load ----------------
    drive(i_lw);
    tick();
    check_out("pre_flush", e_lw);
    drive(vecs[5].in);
    bus.flush = 1'b1;
    tick();
    check_out("flush", bubble_exp());
    bus.flush = 1'b0;

    // ---------------- reset asserted during a stall ----------------
    drive(i_jal);
    tick();
    check_out("pre_rst_stall", e_jal);
    bus.stall = 1'b1;
    drive(i_add);
    reset = 1'b1;
    tick();
    check_out("rst_in_stall", bubble_exp());
    reset     = 1'b0;
    bus.stall = 1'b0;
    tick();
    check_out("after_rst", e_add);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
